// File: rtl/sync_fifo_pkg.sv
// Shared types, default geometry and width helper for the parametrised sync FIFO.
package sync_fifo_pkg;

   typedef enum logic {FIFO_STD = 1'b0, FIFO_FWFT = 1'b1} fifo_mode_e;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_AEMPTY_LVL = 2;

   // A 2-entry FIFO still needs a 1-bit pointer, so never return 0.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// programmable almost flags and registered overflow/underflow pulses.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_DEPTH,
   parameter  int FWFT       = 0,
   parameter  int AFULL_LVL  = DEPTH - 2,
   parameter  int AEMPTY_LVL = DEF_AEMPTY_LVL,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int         PW   = clog2_min1(DEPTH);
   localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be at least 2");
   end
   if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
      $error("sync_fifo_param: AFULL_LVL must be within 1..DEPTH");
   end
   if (AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_bad_aempty
      $error("sync_fifo_param: AEMPTY_LVL must be within 0..DEPTH-1");
   end

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  wr_acc;
   logic                  rd_acc;

   // Explicit wrap so non-power-of-2 depths never index past the last entry.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AFULL_LVL));
   assign almost_empty = (count_q <= CW'(AEMPTY_LVL));
   assign count        = count_q;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (PW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc & rst_n),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_next(rd_ptr);

         if (wr_acc && !rd_acc) begin
            count_q <= count_q + 1'b1;
         end else if (rd_acc && !wr_acc) begin
            count_q <= count_q - 1'b1;
         end

         overflow_q  <= wr_en & full;
         underflow_q <= rd_en & empty;

         if (rd_acc) begin
            rd_data_q  <= mem_rdata;
            rd_valid_q <= 1'b1;
         end else begin
            rd_valid_q <= 1'b0;
         end
      end
   end

   // FWFT presents the head entry straight from the array; it depends only on rd_ptr.
   assign rd_data   = (MODE == FIFO_FWFT) ? mem_rdata : rd_data_q;
   assign rd_valid  = (MODE == FIFO_FWFT) ? ~empty    : rd_valid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, successor to the fixed-geometry 16x16 sync FIFO. It adds the following over that FIFO:
- arbitrary depth (non-power-of-2);
- selectable standard or first-word-fall-through read mode;
- programmable almost-full and almost-empty flags;
- overflow and underflow error pulses;
- a count wide enough to represent a completely full FIFO.

It is the default buffering element between streaming datapath stages.

## Interface
- DATA_WIDTH, 16: bits per entry
- DEPTH, 16: number of entries, ≥2, any integer
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through
- AFULL_LVL, DEPTH-2: almost_full asserts when count ≥ AFULL_LVL
- AEMPTY_LVL, 2: almost_empty asserts when count ≤ AEMPTY_LVL
- CW (localparam), $clog2(DEPTH+1): count width
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request (standard) / pop (FWFT)
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word (see Operation)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LVL
- almost_empty  out  1  count ≤ AEMPTY_LVL
- count  out  CW  entries stored, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
**Accept rules**
- wr_acc = wr_en & ~full.
- rd_acc = rd_en & ~empty.
- Both use the pre-edge state.
- Write when full is rejected even if a read is accepted in the same cycle.
- Read when empty is rejected even if a write is accepted in the same cycle.

**Pointers and count**
- wr_ptr and rd_ptr are $clog2(DEPTH) bits wide.
- Each pointer increments on its accept and wraps from DEPTH-1 to 0; this is an explicit compare, not modulo-2^n.
- count: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither.
- Storage is written at wr_ptr on wr_acc.
- full, empty, almost_full and almost_empty decode combinationally from the registered count.

**Error pulses**
- overflow = registered (wr_en & full).
- underflow = registered (rd_en & empty).
- Each is high for exactly the cycle after the offending request.

**Standard mode (FWFT=0)**
- On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1.
- Otherwise rd_valid <= 0 and rd_data holds its last value.

**FWFT mode (FWFT=1)**
- rd_data = mem[rd_ptr] combinationally.
- rd_valid = ~empty.
- rd_en consumes the presented word.

**Reset** (rst_n low at a rising edge)
- Outputs: count=0, ptrs=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
- Flags: empty=1, full=0, almost_empty=1, almost_full=0 (for AFULL_LVL>0).
- Storage contents are not reset.
- Reset overrides any concurrent wr_en/rd_en and aborts an in-flight read; rd_valid is 0 in the following cycle.

**Parameter checks**
- Elaboration-time assertion: 1 ≤ AFULL_LVL ≤ DEPTH.
- Elaboration-time assertion: 0 ≤ AEMPTY_LVL < DEPTH.

## Timing
- Write to flags: a word written at edge N updates count/flags after edge N.
- Standard-mode latency: rd_en at cycle N gives rd_data/rd_valid after edge N (1 cycle).
- FWFT latency: a word written into an empty FIFO at edge N is on rd_data with rd_valid=1 in cycle N+1. There is no bypass from wr_data.
- Full-rate throughput: one write and one read per cycle, sustained, at any count 1..DEPTH-1.
- No combinational path from wr_en/rd_en to any output, except rd_data in FWFT, which depends only on registered rd_ptr.

## Structure
- Shared package sync_fifo_pkg holds:
  - fifo_mode_e {FIFO_STD, FIFO_FWFT};
  - default-parameter constants;
  - function clog2_min1(n), returning ≥1 for pointer width.
- One sub-module, fifo_mem: simple dual-port array (1W/1R, async read) so the array can be swapped for a vendor RAM.
- Pointer/count/flag logic and read-output stage live in the top.

## Test plan
- Reset, then write 16 words 0x0001..0x0010 (DEPTH=16) → full=1, count=16, almost_full high from count=14; a 17th write → overflow pulse 1 cycle, count stays 16.
- Standard mode: read 16 words → data 0x0001..0x0010 in order, each one cycle after rd_en; empty=1 after the 16th. A further read → underflow pulse, rd_valid=0, rd_data holds 0x0010.
- DEPTH=5, 12 write/read pairs → wrap at index 4→0 with correct data; count never exceeds 5.
- Simultaneous wr_en/rd_en at count=3 for 20 cycles → count stays 3, output order preserved. At count=0 the same → write accepted, underflow pulse, count=1. At count=DEPTH → read accepted, overflow pulse, count=DEPTH-1.
- FWFT=1: write 0xABCD to empty → rd_data=0xABCD, rd_valid=1 next cycle without rd_en; pop → empty=1, rd_valid=0.
- Reset asserted at count=7 during an accepted read → next cycle count=0, empty=1, rd_valid=0, rd_data=0; a post-reset write/read returns the new word, not stale data.
